instr_sequencer: RTL and testbench

- Control sequencer for the simple processor. It latches an 8-bit instruction from DIN and steps a 2-bit time-step counter through T0..T3.
- It drives the read side of the shared bus: register output selects, DIN/G drivers, A/G latch enables and the ALU op.
- It exports tstate, icode and rin to the register write-enable decoder, which generates the Rx write strobes (T1 for mv/mvi, T3 for add/sub).
- It is the producer end of the tstate/icode/rin interface.

---
 rtl/instr_sequencer.sv | 105 ++++++++++
 tb/tb_instr_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Control sequencer for the simple processor: latches an instruction word
// from DIN and steps T0..T3, driving the bus read-side strobes and the ALU op.
// tstate/icode/rin are exported to the register write-enable decoder.
module instr_sequencer (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [7:0] DIN,
    output logic [1:0] tstate,
    output logic [1:0] icode,
    output logic [2:0] rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Gout,
    output logic       IRin,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    tstep_t     state;
    logic [7:0] ir;
    logic [7:0] rx_sel;
    logic [7:0] ry_sel;

    // ir[7] set means add/sub (multi-step); clear means mv/mvi (single step).
    assign tstate = state;
    assign icode  = ir[7:6];
    assign rin    = ir[5:3];
    assign rx_sel = 8'd1 << ir[5:3];
    assign ry_sel = 8'd1 << ir[2:0];

    // Time-step counter and instruction register; T2/T3 without add/sub
    // can only be reached by forcing, so they fall back to T0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= 8'h00;
        end else begin
            case (state)
                T0: begin
                    if (Run) begin
                        ir    <= DIN;
                        state <= T1;
                    end
                end
                T1:      state <= ir[7] ? T2 : T0;
                T2:      state <= ir[7] ? T3 : T0;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Bus and ALU strobes, decoded from the step and IR; all held low in reset
    // so that IRin cannot follow Run while the sequencer is being cleared.
    always_comb begin
        Rout   = 8'h00;
        DINout = 1'b0;
        Gout   = 1'b0;
        IRin   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (Resetn) begin
            case (state)
                T0: IRin = Run;
                T1: begin
                    if (!ir[7]) begin
                        if (!ir[6]) Rout = ry_sel;
                        else        DINout = 1'b1;
                        Done = 1'b1;
                    end else begin
                        Rout = rx_sel;
                        Ain  = 1'b1;
                    end
                end
                T2: begin
                    if (ir[7]) begin
                        Rout   = ry_sel;
                        Gin    = 1'b1;
                        AddSub = ir[6];
                    end
                end
                T3: begin
                    if (ir[7]) begin
                        Gout = 1'b1;
                        Done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed instruction cases, a
// mid-instruction reset, then randomized Run/DIN against a step-list model.
module tb_instr_sequencer;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [7:0] DIN;
    logic [1:0] tstate;
    logic [1:0] icode;
    logic [2:0] rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       Gout;
    logic       IRin;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;

    instr_sequencer dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .tstate (tstate),
        .icode  (icode),
        .rin    (rin),
        .Rout   (Rout),
        .DINout (DINout),
        .Gout   (Gout),
        .IRin   (IRin),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each loaded instruction becomes a list of per-step output records;
    // an empty list means the sequencer sits in T0.
    // Record layout: {tstate, icode, rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
    logic [20:0] exp_q[$];
    logic [1:0]  m_icode;
    logic [2:0]  m_rin;

    function automatic logic [20:0] rec(input int ts, input logic [1:0] ic, input logic [2:0] rn,
                                        input logic [7:0] rout, input bit dinout, input bit gout,
                                        input bit ain, input bit gin, input bit addsub, input bit done);
        return {2'(ts), ic, rn, rout, dinout, gout, ain, gin, addsub, done};
    endfunction

    task automatic model_load(input logic [7:0] d);
        logic [1:0] ic;
        logic [7:0] rx_hot;
        logic [7:0] ry_hot;
        ic      = d[7:6];
        rx_hot  = 8'(1 << d[5:3]);
        ry_hot  = 8'(1 << d[2:0]);
        m_icode = ic;
        m_rin   = d[5:3];
        case (ic)
            2'b00: exp_q.push_back(rec(1, ic, m_rin, ry_hot, 0, 0, 0, 0, 0, 1));
            2'b01: exp_q.push_back(rec(1, ic, m_rin, 8'h00, 1, 0, 0, 0, 0, 1));
            default: begin
                exp_q.push_back(rec(1, ic, m_rin, rx_hot, 0, 0, 1, 0, 0, 0));
                exp_q.push_back(rec(2, ic, m_rin, ry_hot, 0, 0, 0, 1, ic[0], 0));
                exp_q.push_back(rec(3, ic, m_rin, 8'h00, 0, 1, 0, 0, 0, 1));
            end
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_icode = 2'b00;
        m_rin   = 3'b000;
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge: drive, check on the falling edge,
    // then advance the model across the next rising edge.
    task automatic cycle(input bit r, input logic [7:0] d);
        logic [20:0] exp_v;
        logic [20:0] obs_v;
        int          drivers;
        Run = r;
        DIN = d;
        @(negedge Clock);
        exp_v = (exp_q.size() != 0) ? exp_q[0] : rec(0, m_icode, m_rin, 8'h00, 0, 0, 0, 0, 0, 0);
        obs_v = {tstate, icode, rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};
        check("outputs", 32'(obs_v), 32'(exp_v));
        check("irin", 32'(IRin), (exp_q.size() == 0) ? 32'(r) : 32'd0);
        drivers = $countones(Rout) + int'(DINout) + int'(Gout);
        check("bus_excl", 32'(drivers <= 1), 32'd1);
        @(posedge Clock);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (r) model_load(d);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 8'h0A;
        model_reset();
        #12;
        check("rst_tstate", 32'(tstate), 32'd0);
        check("rst_irin", 32'(IRin), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        Run    = 1'b0;
        @(posedge Clock);
        #1;
        cycle(0, 8'h00);

        // mv R1,R2
        cycle(1, 8'h0A);
        check("mv_tstate", 32'(tstate), 32'd1);
        check("mv_icode", 32'(icode), 32'd0);
        check("mv_rin", 32'(rin), 32'd1);
        check("mv_rout", 32'(Rout), 32'h04);
        check("mv_done", 32'(Done), 32'd1);
        cycle(0, 8'h00);
        check("mv_back_t0", 32'(tstate), 32'd0);

        // mvi R5
        cycle(1, 8'h68);
        check("mvi_dinout", 32'(DINout), 32'd1);
        check("mvi_rout", 32'(Rout), 32'h00);
        check("mvi_rin", 32'(rin), 32'd5);
        check("mvi_done", 32'(Done), 32'd1);
        cycle(0, 8'h00);
        check("mvi_back_t0", 32'(tstate), 32'd0);

        // add R3,R2 (Run toggled during T1..T3 must be ignored)
        cycle(1, 8'h9A);
        check("add_t1_rout", 32'(Rout), 32'h08);
        check("add_t1_ain", 32'(Ain), 32'd1);
        cycle(1, 8'hFF);
        check("add_t2_rout", 32'(Rout), 32'h04);
        check("add_t2_gin", 32'(Gin), 32'd1);
        check("add_t2_addsub", 32'(AddSub), 32'd0);
        cycle(0, 8'h00);
        check("add_t3_gout", 32'(Gout), 32'd1);
        check("add_t3_done", 32'(Done), 32'd1);
        check("add_t3_rin", 32'(rin), 32'd3);
        check("add_t3_tstate", 32'(tstate), 32'd3);
        cycle(0, 8'h00);

        // sub R0,R1 then mv R7,R0 with Run held high
        cycle(1, 8'hC1);
        cycle(1, 8'h38);
        check("sub_t2_addsub", 32'(AddSub), 32'd1);
        cycle(1, 8'h38);
        cycle(1, 8'h38);
        check("b2b_t0_irin", 32'(IRin), 32'd1);
        cycle(1, 8'h38);
        check("b2b_mv_rout", 32'(Rout), 32'h01);
        check("b2b_mv_rin", 32'(rin), 32'd7);
        cycle(0, 8'h00);

        // reset in the middle of T2 of an add
        cycle(1, 8'h9A);
        cycle(1, 8'h00);
        Run = 1'b1;
        #1;
        Resetn = 1'b0;
        #1;
        check("midrst_tstate", 32'(tstate), 32'd0);
        check("midrst_icode", 32'(icode), 32'd0);
        check("midrst_rin", 32'(rin), 32'd0);
        check("midrst_rout", 32'(Rout), 32'h00);
        check("midrst_gin", 32'(Gin), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_irin", 32'(IRin), 32'd0);
        model_reset();
        @(negedge Clock);
        Run    = 1'b0;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'($urandom));
            check("idle_tstate", 32'(tstate), 32'd0);
        end

        // randomized Run/DIN
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
